multi_shift_register: RTL and testbench
=======================================

MULTI_SHIFT_REGISTER -- requirements
Module: multi_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 4, shift-amount width; SHALL be >= clog2(WIDTH+1).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 cl  in  1  clear out to 0.
REQ-006 ld  in  1  load out from in.
REQ-007 in  in  WIDTH  load data.
REQ-008 inc / dec  in  1 each  increment / decrement out by 1.
REQ-009 start  in  1  request a multi-bit shift of amt steps.
REQ-010 op  in  3  shift mode: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101-111 reserved.
REQ-011 amt  in  CNT_W  shift count; values above WIDTH SHALL be honoured literally, one step per count.
REQ-012 ir / il  in  1 each  serial fill bit for SRL / SLL.
REQ-013 out  out  WIDTH  register contents.
REQ-014 busy  out  1  high while a shift is in progress.
REQ-015 done  out  1  one-cycle pulse when a shift completes.
REQ-016 carry  out  1  last bit shifted out, or inc/dec wrap flag.
REQ-017 zero  out  1  combinational (out == 0).

Function
REQ-018 FSM states IDLE, SHIFT, DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-019 In IDLE or DONE, command priority SHALL be cl > ld > inc > dec > start; only the highest asserted command acts.
REQ-020 DONE SHALL return to IDLE on the next edge unless a start is accepted in that cycle, in which case it moves to SHIFT.
REQ-021 cl: out <= 0, carry <= 0; ld: out <= in, carry unchanged.
REQ-022 inc: out <= out+1 mod 2^WIDTH; carry <= 1 iff out was all ones, else 0.
REQ-023 dec: out <= out-1 mod 2^WIDTH; carry <= 1 iff out was 0, else 0.
REQ-024 start accepted with amt > 0: latch op, counter <= amt, go to SHIFT; out unchanged on the accepting edge.
REQ-025 start accepted with amt == 0: go directly to DONE; out and carry unchanged.
REQ-026 Each edge in SHIFT performs exactly one 1-bit step using the latched op, decrements counter, and moves to DONE when counter was 1.
REQ-027 A shift of amt = N SHALL hold busy for N cycles, followed by a done pulse in cycle N+1 after acceptance.
REQ-028 SRL fill = ir, SLL fill = il, SRA fill = old MSB; ROR/ROL rotate; ir/il SHALL be sampled live on every step, not latched.
REQ-029 Each step: carry <= bit shifted out (LSB for SRL/SRA/ROR, MSB for SLL/ROL).
REQ-030 Reserved op: out and carry SHALL be unchanged on each step; counter and timing behave normally.
REQ-031 In SHIFT: cl aborts (out <= 0, carry <= 0, state <= IDLE, no done pulse); ld, inc, dec and start are ignored.

Reset
REQ-032 rst_n low at an edge: out = 0, carry = 0, counter = 0, latched op = 000, state = IDLE (busy = 0, done = 0); this overrides all other inputs, including mid-shift.

Structure
REQ-033 Shared package: op encodings (OP_SRL..OP_ROL) and the FSM state enum.
REQ-034 Single sub-module reg_shift_step (combinational, WIDTH-parametrised): (value, op, ir, il) -> (next value, bit out).

Verification (WIDTH=8)
REQ-035 ld 0xA5; start SRL amt=3 ir=1 -> busy 3 cycles, done pulse in cycle 4, out=0xF4, carry=1.
REQ-036 ld 0x81; start ROL amt=8 -> busy 8 cycles, out=0x81, carry=1; then start amt=0 -> done next cycle, out=0x81 unchanged.
REQ-037 ld 0xFF; inc -> out=0x00, carry=1, zero=1; dec -> out=0xFF, carry=1; inc+dec together -> inc wins.
REQ-038 ld 0x90; start SRA amt=2 -> out=0xE4, carry=0; during this shift, ld 0x00 in SHIFT -> ignored.
REQ-039 start SLL amt=5, cl in 2nd SHIFT cycle -> out=0x00, carry=0, busy=0 next cycle, no done pulse.
REQ-040 rst_n low in SHIFT -> next edge out=0, busy=0, done=0, carry=0; rst_n low with cl/ld/start asserted -> reset wins.

Source files
------------

// File: rtl/multi_shift_register_pkg.sv
// rtl/multi_shift_register_pkg.sv - shared op encodings and FSM state type
package multi_shift_register_pkg;

    localparam logic [2:0] OP_SRL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/multi_shift_register_step.sv
// rtl/multi_shift_register_step.sv - one combinational 1-bit shift/rotate step
module reg_shift_step
    import multi_shift_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic             ir,
    input  logic             il,
    output logic [WIDTH-1:0] next_value,
    output logic             bit_out
);

    always_comb begin
        next_value = value;
        bit_out    = 1'b0;
        case (op)
            OP_SRL: begin
                next_value = {ir, value[WIDTH-1:1]};
                bit_out    = value[0];
            end
            OP_SLL: begin
                next_value = {value[WIDTH-2:0], il};
                bit_out    = value[WIDTH-1];
            end
            OP_SRA: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                bit_out    = value[0];
            end
            OP_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                bit_out    = value[0];
            end
            OP_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                bit_out    = value[WIDTH-1];
            end
            default: begin
                next_value = value;
                bit_out    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_shift_register.sv
// rtl/multi_shift_register.sv - loadable up/down register with multi-step shift FSM
module multi_shift_register
    import multi_shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic             ir,
    input  logic             il,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    localparam logic [WIDTH-1:0] VAL_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] step_value;
    logic             step_bit;

    reg_shift_step #(.WIDTH(WIDTH)) u_step (
        .value      (out_q),
        .op         (op_q),
        .ir         (ir),
        .il         (il),
        .next_value (step_value),
        .bit_out    (step_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_SRL;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (state_q == ST_SHIFT) begin
            // Only clear may interrupt a shift; it aborts without a done pulse.
            if (cl) begin
                out_d   = '0;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                out_d   = step_value;
                carry_d = is_shift_op(op_q) ? step_bit : carry_q;
                cnt_d   = cnt_q - CNT_ONE;
                state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_SHIFT;
            end
        end else begin
            state_d = ST_IDLE;
            if (cl) begin
                out_d   = '0;
                carry_d = 1'b0;
            end else if (ld) begin
                out_d = in;
            end else if (inc) begin
                out_d   = out_q + VAL_ONE;
                carry_d = &out_q;
            end else if (dec) begin
                out_d   = out_q - VAL_ONE;
                carry_d = (out_q == '0);
            end else if (start) begin
                if (amt != '0) begin
                    op_d    = op;
                    cnt_d   = amt;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign zero  = (out_q == '0);

endmodule

// File: tb/tb_multi_shift_register.sv
// tb/tb_multi_shift_register.sv - directed and randomized checks against a behavioural model
module tb_multi_shift_register;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cl = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0, start = 1'b0;
    logic [7:0] in = 8'h00;
    logic [2:0] op = 3'b000;
    logic [3:0] amt = 4'd0;
    logic       ir = 1'b0, il = 1'b0;
    logic [7:0] out;
    logic       busy, done, carry, zero;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] m_out = 8'h00;
    logic       m_carry = 1'b0;
    logic [2:0] m_op = 3'b000;
    int         m_rem = 0;
    logic       m_done = 1'b0;

    multi_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
        .start(start), .op(op), .amt(amt), .ir(ir), .il(il),
        .out(out), .busy(busy), .done(done), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_step(input logic [7:0] v, input logic [2:0] o,
                                            input logic r, input logic l, input logic c);
        logic [7:0] n;
        logic       co;
        case (o)
            3'd0: begin co = v[0]; n = (v >> 1) | (r ? 8'h80 : 8'h00); end
            3'd1: begin co = v[7]; n = (v << 1) | {7'd0, l}; end
            3'd2: begin co = v[0]; n = (v >> 1) | (v & 8'h80); end
            3'd3: begin co = v[0]; n = (v >> 1) | (v << 7); end
            3'd4: begin co = v[7]; n = (v << 1) | (v >> 7); end
            default: begin co = c; n = v; end
        endcase
        return {co, n};
    endfunction

    // Advance the reference model on the current inputs, then clock the DUT.
    task automatic tick();
        logic [8:0] s;
        if (!rst_n) begin
            m_out = 8'h00; m_carry = 1'b0; m_rem = 0; m_done = 1'b0; m_op = 3'b000;
        end else if (m_rem > 0) begin
            m_done = 1'b0;
            if (cl) begin
                m_out = 8'h00; m_carry = 1'b0; m_rem = 0;
            end else begin
                s = ref_step(m_out, m_op, ir, il, m_carry);
                m_out = s[7:0]; m_carry = s[8];
                m_rem = m_rem - 1;
                m_done = (m_rem == 0);
            end
        end else begin
            m_done = 1'b0;
            if (cl) begin m_out = 8'h00; m_carry = 1'b0; end
            else if (ld) m_out = in;
            else if (inc) begin m_carry = (m_out == 8'hFF); m_out = m_out + 8'd1; end
            else if (dec) begin m_carry = (m_out == 8'h00); m_out = m_out - 8'd1; end
            else if (start) begin
                if (amt == 4'd0) m_done = 1'b1;
                else begin m_rem = int'(amt); m_op = op; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cl = 0; ld = 0; inc = 0; dec = 0; start = 0;
    endtask

    task automatic load(input logic [7:0] v);
        quiet(); ld = 1; in = v; tick(); ld = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cl = 1; ld = 1; in = 8'hFF; start = 1; amt = 4'd3; inc = 1;
        tick();
        n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out); end
        n_checks++; if ({busy, done, carry, zero} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags: got %b want 0001", {busy, done, carry, zero}); end
        quiet(); rst_n = 1; tick();
    endtask

    task automatic test_srl();
        int busy_cnt = 0;
        load(8'hA5);
        op = 3'b000; amt = 4'd3; ir = 1; start = 1; tick(); start = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        n_checks++; if (busy_cnt != 3) begin n_fail++; $display("FAIL srl_busy_cycles: got %0d want 3", busy_cnt); end
        n_checks++; if ({done, out, carry} !== {1'b1, 8'hF4, 1'b1}) begin n_fail++; $display("FAIL srl_result: got done=%b out=%h c=%b want 1 f4 1", done, out, carry); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL srl_done_pulse: got %b want 0", done); end
        ir = 0;
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        load(8'h81);
        op = 3'b100; amt = 4'd8; start = 1; tick(); start = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        n_checks++; if (busy_cnt != 8) begin n_fail++; $display("FAIL rol_busy_cycles: got %0d want 8", busy_cnt); end
        n_checks++; if ({done, out, carry} !== {1'b1, 8'h81, 1'b1}) begin n_fail++; $display("FAIL rol_result: got done=%b out=%h c=%b want 1 81 1", done, out, carry); end
        amt = 4'd0; start = 1; tick(); start = 0;
        n_checks++; if ({busy, done, out} !== {1'b0, 1'b1, 8'h81}) begin n_fail++; $display("FAIL amt0: got busy=%b done=%b out=%h want 0 1 81", busy, done, out); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL amt0_pulse: got %b want 0", done); end
    endtask

    task automatic test_inc_dec();
        load(8'hFF);
        inc = 1; tick(); inc = 0;
        n_checks++; if ({out, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin n_fail++; $display("FAIL inc_wrap: got out=%h c=%b z=%b want 00 1 1", out, carry, zero); end
        dec = 1; tick(); dec = 0;
        n_checks++; if ({out, carry, zero} !== {8'hFF, 1'b1, 1'b0}) begin n_fail++; $display("FAIL dec_wrap: got out=%h c=%b z=%b want ff 1 0", out, carry, zero); end
        load(8'h10);
        inc = 1; dec = 1; tick(); quiet();
        n_checks++; if ({out, carry} !== {8'h11, 1'b0}) begin n_fail++; $display("FAIL inc_priority: got out=%h c=%b want 11 0", out, carry); end
    endtask

    task automatic test_sra_ignore();
        load(8'h90);
        op = 3'b010; amt = 4'd2; start = 1; tick(); start = 0;
        ld = 1; in = 8'h00; inc = 1; tick(); quiet();
        tick();
        n_checks++; if ({done, out, carry} !== {1'b1, 8'hE4, 1'b0}) begin n_fail++; $display("FAIL sra_result: got done=%b out=%h c=%b want 1 e4 0", done, out, carry); end
        tick();
    endtask

    task automatic test_abort();
        int seen_done = 0;
        load(8'h3C);
        op = 3'b001; amt = 4'd5; il = 1; start = 1; tick(); start = 0;
        tick();
        cl = 1; tick(); cl = 0;
        n_checks++; if ({out, carry, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL abort: got out=%h c=%b busy=%b done=%b want 00 0 0 0", out, carry, busy, done); end
        for (int i = 0; i < 6; i++) begin
            if (done) seen_done++;
            tick();
        end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
        il = 0;
    endtask

    task automatic test_reset_mid_shift();
        load(8'hC3);
        op = 3'b011; amt = 4'd6; start = 1; tick(); start = 0;
        tick(); tick();
        rst_n = 0; tick();
        n_checks++; if ({out, busy, done, carry} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reset_mid_shift: got out=%h busy=%b done=%b c=%b want 00 0 0 0", out, busy, done, carry); end
        rst_n = 1; load(8'h5A);
        rst_n = 0; ld = 1; in = 8'h77; cl = 1; start = 1; amt = 4'd0; tick();
        n_checks++; if ({out, done, busy} !== {8'h00, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reset_priority: got out=%h done=%b busy=%b want 00 0 0", out, done, busy); end
        quiet(); rst_n = 1; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cl    = ($urandom_range(0, 19) == 0);
            ld    = ($urandom_range(0, 3) == 0);
            inc   = ($urandom_range(0, 3) == 0);
            dec   = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 1) == 0);
            in    = 8'($urandom);
            op    = 3'($urandom_range(0, 7));
            amt   = 4'($urandom_range(0, 15));
            ir    = 1'($urandom);
            il    = 1'($urandom);
            tick();
            n_checks++;
            if ({out, carry, busy, done, zero} !== {m_out, m_carry, (m_rem > 0), m_done, (m_out == 8'h00)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got out=%h c=%b busy=%b done=%b z=%b want out=%h c=%b busy=%b done=%b",
                         i, out, carry, busy, done, zero, m_out, m_carry, (m_rem > 0), m_done);
            end
        end
        quiet(); rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_srl();
        test_back_to_back();
        test_inc_dec();
        test_sra_ignore();
        test_abort();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
